// File: rtl/gamma_frame_seq.sv
// Gamma frame sequencer: forwards each gamma vector to the alpha unit as it arrives,
// buffers the frame, then replays it in reverse order to the beta unit.
module gamma_frame_seq #(
    parameter int unsigned W       = 16,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned LEN_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              gin_valid,
    output logic              gin_ready,
    input  logic [16*W-1:0]   gin,
    output logic              fwd_valid,
    input  logic              fwd_ready,
    output logic [16*W-1:0]   fwd_gamma,
    output logic [LEN_W-1:0]  fwd_idx,
    output logic              bwd_valid,
    input  logic              bwd_ready,
    output logic [16*W-1:0]   bwd_gamma,
    output logic [LEN_W-1:0]  bwd_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned GW = 16 * W;
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_BWD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] rem;
    logic [GW-1:0]    mem [MAX_LEN];

    logic [LEN_W-1:0] len_c;
    logic [LEN_W-1:0] rem_m1_c;
    logic             gin_hs_c;
    logic             fwd_hs_c;
    logic             bwd_hs_c;
    logic             bwd_load_c;

    // frame length clamped to buffer depth
    assign len_c    = (frame_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : frame_len;
    assign rem_m1_c = rem - LEN_W'(1);

    assign gin_ready  = (state == S_FWD) && (cnt < len) && (!fwd_valid || fwd_ready);
    assign gin_hs_c   = gin_valid && gin_ready;
    assign fwd_hs_c   = fwd_valid && fwd_ready;
    assign bwd_hs_c   = bwd_valid && bwd_ready;
    // rem counts vectors still to replay, so the read address never wraps
    assign bwd_load_c = (state == S_BWD) && (rem != '0) && (!bwd_valid || bwd_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= (state_nxt == S_DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len_c == '0) ? S_DONE : S_FWD;
                end
            end
            S_FWD: begin
                // all vectors accepted and the last forward beat leaves this cycle
                if ((cnt == len) && (!fwd_valid || fwd_ready)) begin
                    state_nxt = S_BWD;
                end
            end
            S_BWD: begin
                if (bwd_hs_c && (bwd_idx == '0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len       <= '0;
            cnt       <= '0;
            rem       <= '0;
            fwd_valid <= 1'b0;
            fwd_gamma <= '0;
            fwd_idx   <= '0;
            bwd_valid <= 1'b0;
            bwd_gamma <= '0;
            bwd_idx   <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                len <= len_c;
                cnt <= '0;
                rem <= len_c;
            end

            if (gin_hs_c) begin
                fwd_gamma <= gin;
                fwd_idx   <= cnt;
                fwd_valid <= 1'b1;
                cnt       <= cnt + LEN_W'(1);
            end else if (fwd_hs_c) begin
                fwd_valid <= 1'b0;
            end

            if (bwd_load_c) begin
                bwd_gamma <= mem[rem_m1_c[AW-1:0]];
                bwd_idx   <= rem_m1_c;
                bwd_valid <= 1'b1;
                rem       <= rem_m1_c;
            end else if (bwd_hs_c) begin
                bwd_valid <= 1'b0;
            end
        end
    end

    // frame buffer, intentionally not reset
    always_ff @(posedge clk) begin
        if (rst_n && gin_hs_c) begin
            mem[cnt[AW-1:0]] <= gin;
        end
    end

endmodule

// File: tb/tb_gamma_frame_seq.sv
// Bench for gamma_frame_seq: random and directed frames checked against a
// queue model (forward order = arrival order, backward order = reverse).
module tb_gamma_frame_seq;

    localparam int unsigned W       = 16;
    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned LEN_W   = 7;
    localparam int unsigned GW      = 16 * W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             gin_valid;
    logic             gin_ready;
    logic [GW-1:0]    gin;
    logic             fwd_valid;
    logic             fwd_ready;
    logic [GW-1:0]    fwd_gamma;
    logic [LEN_W-1:0] fwd_idx;
    logic             bwd_valid;
    logic             bwd_ready;
    logic [GW-1:0]    bwd_gamma;
    logic [LEN_W-1:0] bwd_idx;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    gamma_frame_seq #(.W(W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .gin_valid(gin_valid), .gin_ready(gin_ready), .gin(gin),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_gamma(fwd_gamma), .fwd_idx(fwd_idx),
        .bwd_valid(bwd_valid), .bwd_ready(bwd_ready), .bwd_gamma(bwd_gamma), .bwd_idx(bwd_idx),
        .busy(busy), .done(done)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    logic [GW-1:0] vecs [64];
    logic [GW-1:0] acc_q[$];
    logic [GW-1:0] fwd_g_q[$];
    logic [GW-1:0] bwd_g_q[$];
    int fwd_i_q[$], bwd_i_q[$], fwd_cyc_q[$], bwd_cyc_q[$];
    int start_cyc, acc_first_cyc, bwd_first_cyc, done_cyc, done_cnt;
    int stall_err, ready_err, post_err, fwd_seen, bwd_seen;
    bit timeout, aborted, pulsed;

    // model: forward beat k carries accepted vector k with index k
    function automatic int fwd_bad();
        for (int k = 0; k < fwd_g_q.size(); k++)
            if (k >= acc_q.size() || fwd_i_q[k] != k || fwd_g_q[k] !== acc_q[k]) return k;
        return -1;
    endfunction

    // model: backward beat k carries accepted vector n-1-k with index n-1-k
    function automatic int bwd_bad();
        int n = acc_q.size();
        for (int k = 0; k < bwd_g_q.size(); k++) begin
            int e = n - 1 - k;
            if (e < 0 || bwd_i_q[k] != e || bwd_g_q[k] !== acc_q[e]) return k;
        end
        return -1;
    endfunction

    // fmode: 0 ready always, 1 toggling, 2 random; bmode: 0 ready always, 2 random
    task automatic run_frame(input int flen, input int fmode, input int bmode, input int bwd_hold,
                             input bit pulse_bwd, input int abort_idx, input bit pattern);
        int  len_exp, hold_left, post_left;
        bit  p_fv, p_fr, p_bv, p_br, finished;
        logic [GW-1:0]    p_fg, p_bg;
        logic [LEN_W-1:0] p_fi, p_bi;
        len_exp = (flen > int'(MAX_LEN)) ? int'(MAX_LEN) : flen;
        for (int k = 0; k < 64; k++)
            for (int j = 0; j < 16; j++)
                vecs[k][j*W +: W] = pattern ? 16'(100 * k + j) : 16'($urandom);
        acc_q.delete(); fwd_g_q.delete(); bwd_g_q.delete();
        fwd_i_q.delete(); bwd_i_q.delete(); fwd_cyc_q.delete(); bwd_cyc_q.delete();
        acc_first_cyc = -1; bwd_first_cyc = -1; done_cyc = -1; done_cnt = 0;
        stall_err = 0; ready_err = 0; post_err = 0; fwd_seen = 0; bwd_seen = 0;
        timeout = 0; aborted = 0; pulsed = 0; finished = 0;
        hold_left = bwd_hold; post_left = -1;
        p_fv = 0; p_fr = 0; p_bv = 0; p_br = 0; p_fg = '0; p_bg = '0; p_fi = '0; p_bi = '0;

        @(posedge clk); #1; cyc++;
        start = 1'b1; frame_len = LEN_W'(flen); gin_valid = 1'b0;
        fwd_ready = 1'b0; bwd_ready = 1'b0; start_cyc = cyc;

        for (int t = 0; t < 3000 && !finished; t++) begin
            @(posedge clk); #1; cyc++;
            start     = 1'b0;
            gin_valid = (fmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            gin       = vecs[(acc_q.size() < 64) ? acc_q.size() : 63];
            fwd_ready = (fmode == 0) ? 1'b1 : (fmode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
            if (bwd_valid && hold_left > 0) begin
                bwd_ready = 1'b0;
                hold_left--;
            end else begin
                bwd_ready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (pulse_bwd && bwd_valid && !pulsed) begin
                start = 1'b1; frame_len = LEN_W'(5); pulsed = 1;
            end
            #1;
            if (abort_idx >= 0 && bwd_valid && int'(bwd_idx) == abort_idx) begin
                aborted = 1;
                break;
            end
            if (p_fv && !p_fr && (fwd_valid !== 1'b1 || fwd_gamma !== p_fg || fwd_idx !== p_fi)) stall_err++;
            if (p_bv && !p_br && (bwd_valid !== 1'b1 || bwd_gamma !== p_bg || bwd_idx !== p_bi)) stall_err++;
            if (gin_ready && (!busy || (fwd_valid && !fwd_ready) || bwd_valid || acc_q.size() >= len_exp))
                ready_err++;
            if (gin_valid && gin_ready) begin
                if (acc_q.size() == 0) acc_first_cyc = cyc;
                acc_q.push_back(gin);
            end
            if (fwd_valid) begin
                fwd_seen++;
                if (fwd_ready) begin
                    fwd_g_q.push_back(fwd_gamma); fwd_i_q.push_back(int'(fwd_idx)); fwd_cyc_q.push_back(cyc);
                end
            end
            if (bwd_valid) begin
                if (bwd_seen == 0) bwd_first_cyc = cyc;
                bwd_seen++;
                if (bwd_ready) begin
                    bwd_g_q.push_back(bwd_gamma); bwd_i_q.push_back(int'(bwd_idx)); bwd_cyc_q.push_back(cyc);
                end
            end
            p_fv = fwd_valid; p_fr = fwd_ready; p_fg = fwd_gamma; p_fi = fwd_idx;
            p_bv = bwd_valid; p_br = bwd_ready; p_bg = bwd_gamma; p_bi = bwd_idx;
            // after done, watch a few idle cycles before returning
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (post_left < 0) post_left = 3;
            end else if (post_left > 0) begin
                if (busy || fwd_valid || bwd_valid || gin_ready) post_err++;
                post_left--;
                if (post_left == 0) finished = 1;
            end
        end
        timeout = !finished && !aborted;
        start = 1'b0; gin_valid = 1'b0; fwd_ready = 1'b0; bwd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; gin_valid = 1'b1; frame_len = LEN_W'(5);
        fwd_ready = 1'b1; bwd_ready = 1'b1; gin = {8{32'($urandom)}};
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({fwd_valid, bwd_valid, gin_ready, done, busy} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {fwd_valid, bwd_valid, gin_ready, done, busy}); else n_pass++;
        n_chk++; if (fwd_idx !== '0 || bwd_idx !== '0 || fwd_gamma !== '0 || bwd_gamma !== '0)
            $display("FAIL reset_data got fi=%0d bi=%0d want 0", fwd_idx, bwd_idx); else n_pass++;
        start = 1'b0; gin_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if ({busy, gin_ready, done} !== 3'b0)
            $display("FAIL reset_idle got %b want 000", {busy, gin_ready, done}); else n_pass++;
    endtask

    task automatic test_basic();
        int f0, fl, b0, bl;
        logic [GW-1:0] v;
        logic [W-1:0]  lane;
        run_frame(4, 0, 0, 0, 0, -1, 1);
        f0 = (fwd_cyc_q.size() > 0) ? fwd_cyc_q[0] : -100;
        fl = (fwd_cyc_q.size() > 0) ? fwd_cyc_q[fwd_cyc_q.size()-1] : -100;
        b0 = (bwd_cyc_q.size() > 0) ? bwd_cyc_q[0] : -100;
        bl = (bwd_cyc_q.size() > 0) ? bwd_cyc_q[bwd_cyc_q.size()-1] : -100;
        v    = (bwd_g_q.size() > 1) ? bwd_g_q[1] : '0;
        lane = v[5*W +: W];
        n_chk++; if (timeout !== 1'b0) $display("FAIL t2_timeout got %0d want 0", timeout); else n_pass++;
        n_chk++; if (acc_q.size() !== 4) $display("FAIL t2_accepted got %0d want 4", acc_q.size()); else n_pass++;
        n_chk++; if (fwd_g_q.size() !== 4) $display("FAIL t2_fwd_beats got %0d want 4", fwd_g_q.size()); else n_pass++;
        n_chk++; if (fwd_bad() !== -1) $display("FAIL t2_fwd_order got bad beat %0d want -1", fwd_bad()); else n_pass++;
        n_chk++; if (bwd_g_q.size() !== 4) $display("FAIL t2_bwd_beats got %0d want 4", bwd_g_q.size()); else n_pass++;
        n_chk++; if (bwd_bad() !== -1) $display("FAIL t2_bwd_order got bad beat %0d want -1", bwd_bad()); else n_pass++;
        n_chk++; if (lane !== 16'd205) $display("FAIL t2_lane5_idx2 got %0d want 205", lane); else n_pass++;
        n_chk++; if (f0 !== acc_first_cyc + 1) $display("FAIL t2_fwd_latency got %0d want %0d", f0, acc_first_cyc + 1); else n_pass++;
        n_chk++; if (fl - f0 !== 3) $display("FAIL t2_fwd_rate got span %0d want 3", fl - f0); else n_pass++;
        n_chk++; if (b0 !== fl + 2) $display("FAIL t2_bwd_first got %0d want %0d", b0, fl + 2); else n_pass++;
        n_chk++; if (bl - b0 !== 3) $display("FAIL t2_bwd_rate got span %0d want 3", bl - b0); else n_pass++;
        n_chk++; if (done_cyc !== bl + 1) $display("FAIL t2_done_time got %0d want %0d", done_cyc, bl + 1); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL t2_done_pulse got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        int b0;
        run_frame(3, 1, 0, 5, 0, -1, 0);
        b0 = (bwd_cyc_q.size() > 0) ? bwd_cyc_q[0] : -100;
        n_chk++; if (timeout !== 1'b0) $display("FAIL t3_timeout got %0d want 0", timeout); else n_pass++;
        n_chk++; if (stall_err !== 0) $display("FAIL t3_stable got %0d errors want 0", stall_err); else n_pass++;
        n_chk++; if (ready_err !== 0) $display("FAIL t3_gin_ready got %0d errors want 0", ready_err); else n_pass++;
        n_chk++; if (fwd_g_q.size() !== 3) $display("FAIL t3_fwd_beats got %0d want 3", fwd_g_q.size()); else n_pass++;
        n_chk++; if (fwd_bad() !== -1) $display("FAIL t3_fwd_order got bad beat %0d want -1", fwd_bad()); else n_pass++;
        n_chk++; if (bwd_g_q.size() !== 3) $display("FAIL t3_bwd_beats got %0d want 3", bwd_g_q.size()); else n_pass++;
        n_chk++; if (bwd_bad() !== -1) $display("FAIL t3_bwd_order got bad beat %0d want -1", bwd_bad()); else n_pass++;
        n_chk++; if (b0 !== bwd_first_cyc + 5) $display("FAIL t3_bwd_hold got %0d want %0d", b0, bwd_first_cyc + 5); else n_pass++;
        n_chk++; if (done_cnt !== 1 || post_err !== 0)
            $display("FAIL t3_done got pulses=%0d post_err=%0d want 1,0", done_cnt, post_err); else n_pass++;
    endtask

    task automatic test_zero_len();
        run_frame(0, 0, 0, 0, 0, -1, 0);
        n_chk++; if (timeout !== 1'b0) $display("FAIL t4_timeout got %0d want 0", timeout); else n_pass++;
        n_chk++; if (done_cyc !== start_cyc + 1) $display("FAIL t4_done_time got %0d want %0d", done_cyc, start_cyc + 1); else n_pass++;
        n_chk++; if (fwd_seen !== 0 || bwd_seen !== 0)
            $display("FAIL t4_no_valid got fwd=%0d bwd=%0d want 0,0", fwd_seen, bwd_seen); else n_pass++;
        n_chk++; if (acc_q.size() !== 0 || ready_err !== 0)
            $display("FAIL t4_no_accept got acc=%0d rerr=%0d want 0,0", acc_q.size(), ready_err); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL t4_done_pulse got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_max_len();
        run_frame(100, 2, 2, 0, 1, -1, 0);
        n_chk++; if (timeout !== 1'b0) $display("FAIL t5_timeout got %0d want 0", timeout); else n_pass++;
        n_chk++; if (pulsed !== 1'b1) $display("FAIL t5_bwd_start_applied got %0d want 1", pulsed); else n_pass++;
        n_chk++; if (acc_q.size() !== 64) $display("FAIL t5_accepted got %0d want 64", acc_q.size()); else n_pass++;
        n_chk++; if (fwd_g_q.size() !== 64) $display("FAIL t5_fwd_beats got %0d want 64", fwd_g_q.size()); else n_pass++;
        n_chk++; if (bwd_g_q.size() !== 64) $display("FAIL t5_bwd_beats got %0d want 64", bwd_g_q.size()); else n_pass++;
        n_chk++; if (fwd_bad() !== -1 || bwd_bad() !== -1)
            $display("FAIL t5_order got fwd=%0d bwd=%0d want -1,-1", fwd_bad(), bwd_bad()); else n_pass++;
        n_chk++; if (stall_err !== 0 || ready_err !== 0)
            $display("FAIL t5_handshake got stall=%0d ready=%0d want 0,0", stall_err, ready_err); else n_pass++;
        n_chk++; if (done_cnt !== 1 || post_err !== 0)
            $display("FAIL t5_done got pulses=%0d post_err=%0d want 1,0", done_cnt, post_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        run_frame(20, 0, 0, 0, 0, 10, 0);
        n_chk++; if (aborted !== 1'b1) $display("FAIL t6_reached_idx10 got %0d want 1", aborted); else n_pass++;
        n_chk++; if (bwd_g_q.size() !== 9 || bwd_bad() !== -1)
            $display("FAIL t6_partial_bwd got beats=%0d bad=%0d want 9,-1", bwd_g_q.size(), bwd_bad()); else n_pass++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_chk++; if ({fwd_valid, bwd_valid, gin_ready, done, busy} !== 5'b0 || bwd_idx !== '0)
            $display("FAIL t6_reset_flags got %b idx=%0d want 00000 0", {fwd_valid, bwd_valid, gin_ready, done, busy}, bwd_idx); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(2, 2, 2, 0, 0, -1, 0);
        n_chk++; if (timeout !== 1'b0) $display("FAIL t6_timeout got %0d want 0", timeout); else n_pass++;
        n_chk++; if (fwd_g_q.size() !== 2 || bwd_g_q.size() !== 2)
            $display("FAIL t6_beats got fwd=%0d bwd=%0d want 2,2", fwd_g_q.size(), bwd_g_q.size()); else n_pass++;
        n_chk++; if (fwd_bad() !== -1 || bwd_bad() !== -1)
            $display("FAIL t6_order got fwd=%0d bwd=%0d want -1,-1", fwd_bad(), bwd_bad()); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL t6_done_pulse got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int flen, exp_len;
            flen    = $urandom_range(1, 72);
            exp_len = (flen > 64) ? 64 : flen;
            run_frame(flen, 2, 2, $urandom_range(0, 3), 0, -1, 0);
            n_chk++; if (timeout !== 1'b0) $display("FAIL rnd%0d_timeout got %0d want 0", f, timeout); else n_pass++;
            n_chk++; if (acc_q.size() !== exp_len || fwd_g_q.size() !== exp_len || bwd_g_q.size() !== exp_len)
                $display("FAIL rnd%0d_counts got acc=%0d fwd=%0d bwd=%0d want %0d", f, acc_q.size(), fwd_g_q.size(), bwd_g_q.size(), exp_len);
                else n_pass++;
            n_chk++; if (fwd_bad() !== -1) $display("FAIL rnd%0d_fwd_order got bad beat %0d want -1", f, fwd_bad()); else n_pass++;
            n_chk++; if (bwd_bad() !== -1) $display("FAIL rnd%0d_bwd_order got bad beat %0d want -1", f, bwd_bad()); else n_pass++;
            n_chk++; if (stall_err !== 0 || ready_err !== 0)
                $display("FAIL rnd%0d_handshake got stall=%0d ready=%0d want 0,0", f, stall_err, ready_err); else n_pass++;
            n_chk++; if (done_cnt !== 1 || post_err !== 0)
                $display("FAIL rnd%0d_done got pulses=%0d post_err=%0d want 1,0", f, done_cnt, post_err); else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; frame_len = '0; gin_valid = 1'b0;
        gin = '0; fwd_ready = 1'b0; bwd_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_max_len();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
